// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and the stall/flush
// sequencer. The datapath (master) reports hazard events; the sequencer
// (slave) answers with per-stage stall/flush strobes and the PC redirect.
interface pipe_hazard_ctrl_if;
  logic       i_stall;
  logic       d_stall;
  logic       div_startE;
  logic       div_readyE;
  logic [4:0] rsD;
  logic [4:0] rtD;
  logic [4:0] writeregE;
  logic       regwriteE;
  logic       memtoregE;
  logic       branch_flushE;
  logic       exceptM;
  logic       eretM;

  logic       stallF;
  logic       stallD;
  logic       stallE;
  logic       stallM;
  logic       stallW;
  logic       flushD;
  logic       flushE;
  logic       flushM;
  logic       flushW;
  logic       redirect_valid;
  logic [1:0] redirect_sel;

  modport master (
    output i_stall, d_stall, div_startE, div_readyE,
    output rsD, rtD, writeregE, regwriteE, memtoregE,
    output branch_flushE, exceptM, eretM,
    input  stallF, stallD, stallE, stallM, stallW,
    input  flushD, flushE, flushM, flushW,
    input  redirect_valid, redirect_sel
  );

  modport slave (
    input  i_stall, d_stall, div_startE, div_readyE,
    input  rsD, rtD, writeregE, regwriteE, memtoregE,
    input  branch_flushE, exceptM, eretM,
    output stallF, stallD, stallE, stallM, stallW,
    output flushD, flushE, flushM, flushW,
    output redirect_valid, redirect_sel
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the five-stage pipeline. All strobes are
// combinational; the only state is whether a stale I-cache refill (issued for
// the pre-redirect PC) still has to be discarded.
module pipe_hazard_ctrl (
  input  logic                 clk,
  input  logic                 rst,
  pipe_hazard_ctrl_if.slave    hz
);

  localparam logic [0:0] RUN    = 1'b0;
  localparam logic [0:0] REFILL = 1'b1;

  localparam logic [1:0] SEL_BRANCH = 2'b01;
  localparam logic [1:0] SEL_EXCVEC = 2'b10;
  localparam logic [1:0] SEL_EPC    = 2'b11;

  logic [0:0] state;
  logic [0:0] state_next;

  logic       mem_stall;
  logic       load_use;
  logic       exc;
  logic [1:0] exc_sel;

  logic       stall_all;
  logic       stall_f;
  logic       stall_d;
  logic       flush_d;
  logic       flush_e;
  logic       flush_mw;
  logic       redir;
  logic [1:0] redir_sel;

  assign mem_stall = hz.d_stall | (hz.div_startE & ~hz.div_readyE);
  assign load_use  = hz.regwriteE & hz.memtoregE & (hz.writeregE != 5'd0) &
                     ((hz.writeregE == hz.rsD) | (hz.writeregE == hz.rtD));
  assign exc       = hz.exceptM | hz.eretM;
  assign exc_sel   = hz.eretM ? SEL_EPC : SEL_EXCVEC;

  // Prioritised hazard resolution: memory freezes everything, then exception
  // redirects, then I-miss freeze, branch redirect and load-use bubble.
  always_comb begin
    stall_all  = 1'b0;
    stall_f    = 1'b0;
    stall_d    = 1'b0;
    flush_d    = 1'b0;
    flush_e    = 1'b0;
    flush_mw   = 1'b0;
    redir      = 1'b0;
    redir_sel  = 2'b00;
    state_next = state;
    if (mem_stall) begin
      stall_all = 1'b1;
    end else if (exc) begin
      flush_d   = 1'b1;
      flush_e   = 1'b1;
      flush_mw  = 1'b1;
      redir     = 1'b1;
      redir_sel = exc_sel;
      if (state == RUN) begin
        state_next = hz.i_stall ? REFILL : RUN;
      end
    end else if (state == REFILL) begin
      stall_f = 1'b1;
      flush_d = 1'b1;
      if (!hz.i_stall) begin
        state_next = RUN;
      end
    end else if (hz.i_stall) begin
      stall_all = 1'b1;
    end else if (hz.branch_flushE) begin
      flush_d   = 1'b1;
      redir     = 1'b1;
      redir_sel = SEL_BRANCH;
    end else if (load_use) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  // Refill-discard state; reset drops any pending discard immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  assign hz.stallF         = stall_all | stall_f;
  assign hz.stallD         = stall_all | stall_d;
  assign hz.stallE         = stall_all;
  assign hz.stallM         = stall_all;
  assign hz.stallW         = stall_all;
  assign hz.flushD         = flush_d;
  assign hz.flushE         = flush_e;
  assign hz.flushM         = flush_mw;
  assign hz.flushW         = flush_mw;
  assign hz.redirect_valid = redir;
  assign hz.redirect_sel   = redir_sel;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus a
// randomized run, each cycle compared against a rule-level reference model.
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic       rst;
    logic       i_stall;
    logic       d_stall;
    logic       div_startE;
    logic       div_readyE;
    logic [4:0] rsD;
    logic [4:0] rtD;
    logic [4:0] writeregE;
    logic       regwriteE;
    logic       memtoregE;
    logic       branch_flushE;
    logic       exceptM;
    logic       eretM;
  } stim_t;

  // Output vector: {stallF..W, flushD..W, redirect_valid, redirect_sel}
  localparam logic [11:0] OUT_IDLE   = 12'b00000_0000_0_00;
  localparam logic [11:0] OUT_STALL  = 12'b11111_0000_0_00;
  localparam logic [11:0] OUT_LDUSE  = 12'b11000_0100_0_00;
  localparam logic [11:0] OUT_BRANCH = 12'b00000_1000_1_01;
  localparam logic [11:0] OUT_EXC    = 12'b00000_1111_1_10;
  localparam logic [11:0] OUT_ERET   = 12'b00000_1111_1_11;
  localparam logic [11:0] OUT_REFILL = 12'b10000_1000_0_00;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  bit   modelRefill;

  pipe_hazard_ctrl_if hz ();

  pipe_hazard_ctrl dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [11:0] observed, input logic [11:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %b, expected %b at %0t", tag, observed, expected, $time);
    end
  endtask

  // Reference: walk the hazard rules in priority order on abstract flags.
  function automatic void model(input stim_t s, input bit refillIn,
                                output logic [11:0] expected, output bit refillOut);
    bit refill;
    bit memStall;
    bit loadUse;
    bit exc;
    refill   = s.rst ? 1'b0 : refillIn;
    memStall = s.d_stall || (s.div_startE && !s.div_readyE);
    loadUse  = s.regwriteE && s.memtoregE && (s.writeregE != 0) &&
               ((s.writeregE == s.rsD) || (s.writeregE == s.rtD));
    exc      = s.exceptM || s.eretM;
    refillOut = refill;
    if (memStall) begin
      expected = OUT_STALL;
    end else if (exc) begin
      expected = s.eretM ? OUT_ERET : OUT_EXC;
      if (!refill) refillOut = s.i_stall;
    end else if (refill) begin
      expected  = OUT_REFILL;
      refillOut = s.i_stall;
    end else if (s.i_stall) begin
      expected = OUT_STALL;
    end else if (s.branch_flushE) begin
      expected = OUT_BRANCH;
    end else if (loadUse) begin
      expected = OUT_LDUSE;
    end else begin
      expected = OUT_IDLE;
    end
    if (s.rst) refillOut = 1'b0;
  endfunction

  // Drive one cycle of inputs at the falling edge, sample 1ns later.
  task automatic applyStimulus(input string tag, input stim_t s, output logic [11:0] observed);
    logic [11:0] expected;
    bit nextRefill;
    @(negedge clk);
    rst              = s.rst;
    hz.i_stall       = s.i_stall;
    hz.d_stall       = s.d_stall;
    hz.div_startE    = s.div_startE;
    hz.div_readyE    = s.div_readyE;
    hz.rsD           = s.rsD;
    hz.rtD           = s.rtD;
    hz.writeregE     = s.writeregE;
    hz.regwriteE     = s.regwriteE;
    hz.memtoregE     = s.memtoregE;
    hz.branch_flushE = s.branch_flushE;
    hz.exceptM       = s.exceptM;
    hz.eretM         = s.eretM;
    #1;
    observed = {hz.stallF, hz.stallD, hz.stallE, hz.stallM, hz.stallW,
                hz.flushD, hz.flushE, hz.flushM, hz.flushW,
                hz.redirect_valid, hz.redirect_sel};
    model(s, modelRefill, expected, nextRefill);
    checkOutput(tag, observed, expected);
    modelRefill = nextRefill;
  endtask

  function automatic stim_t idleStim();
    stim_t s;
    s = '0;
    return s;
  endfunction

  initial begin
    stim_t       s;
    logic [11:0] obs;
    checks      = 0;
    failures    = 0;
    modelRefill = 1'b0;

    s = idleStim();
    s.rst = 1'b1;
    applyStimulus("reset", s, obs);
    checkOutput("reset_const", obs, OUT_IDLE);
    s.rst = 1'b0;
    applyStimulus("idle", s, obs);
    checkOutput("idle_const", obs, OUT_IDLE);

    // Load-use on rs, then same with $zero destination.
    s = idleStim();
    s.regwriteE = 1'b1; s.memtoregE = 1'b1; s.writeregE = 5'd5; s.rsD = 5'd5;
    applyStimulus("loaduse", s, obs);
    checkOutput("loaduse_const", obs, OUT_LDUSE);
    s.writeregE = 5'd0; s.rsD = 5'd0;
    applyStimulus("loaduse_r0", s, obs);
    checkOutput("loaduse_r0_const", obs, OUT_IDLE);

    // Branch mispredict.
    s = idleStim();
    s.branch_flushE = 1'b1;
    applyStimulus("branch", s, obs);
    checkOutput("branch_const", obs, OUT_BRANCH);

    // Exception held off by D-cache stall for 3 cycles.
    s = idleStim();
    s.exceptM = 1'b1; s.d_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus("exc_dstall", s, obs);
      checkOutput("exc_dstall_const", obs, OUT_STALL);
    end
    s.d_stall = 1'b0;
    applyStimulus("exc_after_dstall", s, obs);
    checkOutput("exc_after_dstall_const", obs, OUT_EXC);
    applyStimulus("idle", idleStim(), obs);

    // Exception / ERET during I-miss: redirect, 4 refill, discard, run.
    for (int k = 0; k < 2; k++) begin
      s = idleStim();
      s.i_stall = 1'b1;
      if (k == 0) s.exceptM = 1'b1; else s.eretM = 1'b1;
      applyStimulus("exc_imiss", s, obs);
      checkOutput("exc_imiss_const", obs, (k == 0) ? OUT_EXC : OUT_ERET);
      s = idleStim();
      s.i_stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
        applyStimulus("refill_wait", s, obs);
        checkOutput("refill_wait_const", obs, OUT_REFILL);
      end
      s.i_stall = 1'b0;
      applyStimulus("refill_discard", s, obs);
      checkOutput("refill_discard_const", obs, OUT_REFILL);
      applyStimulus("refill_done", s, obs);
      checkOutput("refill_done_const", obs, OUT_IDLE);
    end

    // Divider busy for 10 cycles, then ready.
    s = idleStim();
    s.div_startE = 1'b1;
    for (int i = 0; i < 10; i++) begin
      applyStimulus("div_busy", s, obs);
      checkOutput("div_busy_const", obs, OUT_STALL);
    end
    s.div_readyE = 1'b1;
    applyStimulus("div_ready", s, obs);
    checkOutput("div_ready_const", obs, OUT_IDLE);

    // Reset during REFILL: no discard cycle afterwards.
    s = idleStim();
    s.exceptM = 1'b1; s.i_stall = 1'b1;
    applyStimulus("exc_imiss2", s, obs);
    s = idleStim();
    s.i_stall = 1'b1;
    applyStimulus("refill_wait2", s, obs);
    checkOutput("refill_wait2_const", obs, OUT_REFILL);
    s = idleStim();
    s.rst = 1'b1;
    applyStimulus("rst_in_refill", s, obs);
    checkOutput("rst_in_refill_const", obs, OUT_IDLE);
    s.rst = 1'b0;
    applyStimulus("after_rst", s, obs);
    checkOutput("after_rst_const", obs, OUT_IDLE);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      s = idleStim();
      s.rst           = ($urandom_range(99) < 2);
      s.i_stall       = ($urandom_range(99) < 30);
      s.d_stall       = ($urandom_range(99) < 10);
      s.div_startE    = ($urandom_range(99) < 10);
      s.div_readyE    = ($urandom_range(99) < 50);
      s.rsD           = 5'($urandom_range(7));
      s.rtD           = 5'($urandom_range(7));
      s.writeregE     = 5'($urandom_range(7));
      s.regwriteE     = ($urandom_range(99) < 60);
      s.memtoregE     = ($urandom_range(99) < 60);
      s.branch_flushE = ($urandom_range(99) < 20);
      s.exceptM       = ($urandom_range(99) < 10);
      s.eretM         = ($urandom_range(99) < 6);
      applyStimulus("random", s, obs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
